// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel edge detector output path.
// Carries the FIFO entry layout and the lane/byte-mask helpers.
package sobel_pkg;

  localparam int PIX_W  = 8;
  localparam int WORD_W = 32;
  localparam int LANES  = 4;

  typedef struct packed {
    logic [LANES-1:0]  bmask;
    logic [WORD_W-1:0] data;
  } out_entry_t;

  // Mask covering the first n lanes of a partial word.
  function automatic logic [LANES-1:0] lane_mask(input logic [1:0] n);
    return (4'b0001 << n) - 4'b0001;
  endfunction

  // Expand a per-lane mask into a per-bit mask over the word.
  function automatic logic [WORD_W-1:0] mask_to_bits(input logic [LANES-1:0] m);
    logic [WORD_W-1:0] bits;
    bits = '0;
    for (int i = 0; i < LANES; i++) begin
      bits[i*PIX_W +: PIX_W] = {PIX_W{m[i]}};
    end
    return bits;
  endfunction

endpackage

// File: rtl/edge_fifo.sv
// Synchronous FIFO of packed output entries with a registered head word.
// Pushes arriving while full are dropped unless a pop frees the slot in the same cycle.
module edge_fifo
  import sobel_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       push,
  input  out_entry_t push_entry,
  input  logic       pop_req,
  output out_entry_t head,
  output logic       req,
  output logic       full,
  output logic       drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  out_entry_t    r_mem [DEPTH];
  out_entry_t    r_head;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic          w_pop;
  logic          w_wr;
  logic [AW-1:0] w_rd_next;
  logic [CW-1:0] w_count_next;
  out_entry_t    w_head_next;

  assign req  = (r_count != '0);
  assign full = (r_count == CW'(DEPTH));
  assign head = r_head;

  assign w_pop = req && pop_req;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign w_wr  = push && (!full || w_pop);
  assign drop  = push && full && !w_pop;

  assign w_rd_next    = w_pop ? r_rd_ptr + AW'(1) : r_rd_ptr;
  assign w_count_next = r_count + CW'(w_wr) - CW'(w_pop);

  // The new head may be the entry being written this cycle, so bypass the array.
  always_comb begin
    w_head_next = r_mem[w_rd_next];
    if (w_wr && (r_wr_ptr == w_rd_next)) begin
      w_head_next = push_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= push_entry;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_head   <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      r_rd_ptr <= w_rd_next;
      r_count  <= w_count_next;
      r_head   <= w_head_next;
    end
  end

endmodule

// File: rtl/edge_output_packer.sv
// Packs four 8-bit edge magnitudes per 32-bit word, flushes partial words at
// end of frame with a byte mask, and queues words for the bus writer.
module edge_output_packer
  import sobel_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              output_enable,
  input  logic [PIX_W-1:0]  edge_data,
  input  logic              frame_end,
  input  logic              clear,
  output logic              out_req,
  output logic [WORD_W-1:0] out_data,
  output logic [LANES-1:0]  out_bmask,
  input  logic              out_ack,
  output logic              fifo_full,
  output logic              overflow
);

  logic [WORD_W-1:0] r_pack;
  logic [1:0]        r_lane;
  logic              r_overflow;

  logic [WORD_W-1:0] w_pack_wr;
  logic [1:0]        w_lane_upd;
  logic              w_word_done;
  logic              w_flush;
  logic              w_push;
  logic [LANES-1:0]  w_push_mask;
  out_entry_t        w_push_entry;
  out_entry_t        w_head;
  logic              w_drop;

  always_comb begin
    w_pack_wr = r_pack;
    if (output_enable) begin
      w_pack_wr[r_lane*PIX_W +: PIX_W] = edge_data;
    end
  end

  assign w_lane_upd  = output_enable ? r_lane + 2'd1 : r_lane;
  assign w_word_done = output_enable && (r_lane == 2'd3);
  // Flush sees the lane count after this cycle's byte, so a completing byte never pushes twice.
  assign w_flush     = frame_end && !w_word_done && (w_lane_upd != 2'd0);
  assign w_push      = w_word_done || w_flush;
  assign w_push_mask = w_word_done ? 4'b1111 : lane_mask(w_lane_upd);

  always_comb begin
    w_push_entry       = '0;
    w_push_entry.bmask = w_push_mask;
    w_push_entry.data  = w_pack_wr & mask_to_bits(w_push_mask);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_pack <= '0;
      r_lane <= '0;
    end else if (w_flush) begin
      r_pack <= '0;
      r_lane <= '0;
    end else begin
      r_pack <= w_pack_wr;
      r_lane <= w_lane_upd;
    end
  end

  // A drop in the same cycle as clear wins, so no lost word goes unreported.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (clear) begin
      r_overflow <= 1'b0;
    end
  end

  edge_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .n_rst      (n_rst),
    .push       (w_push),
    .push_entry (w_push_entry),
    .pop_req    (out_ack),
    .head       (w_head),
    .req        (out_req),
    .full       (fifo_full),
    .drop       (w_drop)
  );

  assign out_data  = w_head.data;
  assign out_bmask = w_head.bmask;
  assign overflow  = r_overflow;

endmodule

// File: doc/edge_output_packer.md
# edge_output_packer

Downstream stage of the Sobel edge detector's main control unit. Each cycle the control unit asserts `output_enable`, this block captures one 8-bit edge magnitude from the calculator. It packs four magnitudes into a 32-bit word and queues the word in a small FIFO. The bus write interface drains the FIFO through a req/ack handshake. End-of-frame flushes a partial word with a byte mask, and FIFO overrun is flagged stickily.

## Interface
Parameters:
- `DEPTH`, 4: FIFO depth in 32-bit words; power of two, at least 2.

Ports:
- `clk`  in  1  clock, rising edge.
- `n_rst`  in  1  reset; asynchronous, active-low.
- `output_enable`  in  1  capture `edge_data` this cycle.
- `edge_data`  in  8  edge magnitude from the calculator.
- `frame_end`  in  1  single-cycle pulse; flush the partial word.
- `clear`  in  1  synchronous clear of the sticky `overflow` flag.
- `out_req`  out  1  FIFO not empty; head word valid.
- `out_data`  out  32  FIFO head word; byte lane 0 = first pixel.
- `out_bmask`  out  4  valid-byte mask of the head word.
- `out_ack`  in  1  consumer accepts the head word this cycle.
- `fifo_full`  out  1  FIFO holds `DEPTH` words.
- `overflow`  out  1  sticky: a push was dropped.

## Operation
- Packer:
  - Holds a 32-bit register `pack` and a 2-bit lane counter `lane`, reset to 0.
  - On `output_enable`, `edge_data` is written to byte `lane` (bits 8*lane+7:8*lane).
  - `lane` then increments, wrapping 3 to 0.
  - When the write fills lane 3, the completed word is pushed with mask 4'b1111.
- Flush:
  - On `frame_end` with `lane` != 0, the partial word is pushed with mask = (1<<lane)-1.
  - `lane` then returns to 0 and unused lanes are forced to 0.
  - On `frame_end` with `lane` == 0, nothing is pushed.
- Same-cycle `output_enable` and `frame_end`:
  - The byte is written first, then the flush rule uses the updated lane count.
  - If the byte filled lane 3, exactly one push occurs (mask 4'b1111).
- FIFO:
  - Circular buffer of {mask, word} entries with read/write pointers and a count of width clog2(DEPTH)+1.
  - Pop when `out_req && out_ack`.
  - `out_ack` while `out_req` is low is ignored.
- Full:
  - A push while full and not popping in the same cycle is dropped and sets `overflow`.
  - A push and pop in the same cycle while full both succeed; the count is unchanged.
- Empty: a push and pop in the same cycle while empty is not possible, because `out_req` is low.
- `overflow` stays set until `clear`. If `clear` and a new drop occur in the same cycle, `overflow` remains 1.
- Packer contents are not affected by FIFO state. A dropped word is lost and packing continues.

## Timing
- Reset: `out_req`=0, `out_data`=0, `out_bmask`=0, `fifo_full`=0, `overflow`=0, `lane`=0, `pack`=0, pointers and count = 0.
- Reset mid-frame discards the partial word and all queued words.
- Push latency:
  - The word is pushed at the clock edge that samples the completing `output_enable` or `frame_end`.
  - `out_req` and the head word are visible in the following cycle.
- `out_data` and `out_bmask` are registered FIFO outputs, stable while `out_req` is high and `out_ack` is low.
- Pop: after `out_ack` is sampled high, the next entry (or `out_req`=0) appears the next cycle.
- Throughput: one pixel per cycle in, one word per cycle out.
- `fifo_full` is combinational from the count, valid the same cycle the count changes.

## Structure
- Shared package `sobel_pkg`:
  - `PIX_W`=8.
  - `WORD_W`=32.
  - `LANES`=4.
  - typedef `out_entry_t` struct {logic [3:0] bmask; logic [31:0] data}.
- Sub-module `edge_fifo` (parameter DEPTH): synchronous FIFO of `out_entry_t` with push, pop, full, empty and drop detection.
- The top level holds the packer, lane counter, flush logic and overflow flag.

## Test plan
- Pixels 0x11, 0x22, 0x33, 0x44 on consecutive `output_enable` cycles -> next cycle `out_req`=1, `out_data`=0x44332211, `out_bmask`=4'b1111.
- Pixels 0xAA, 0xBB, then `frame_end` -> `out_data`=0x0000BBAA, `out_bmask`=4'b0011, `lane` back to 0.
- Fourth pixel 0x04 coincident with `frame_end` after 0x01, 0x02, 0x03 -> exactly one word 0x04030201, mask 4'b1111, FIFO count 1.
- DEPTH=4, `out_ack`=0, 20 pixels -> `fifo_full`=1 after the 16th pixel, `overflow`=1 after the 20th. The first four words are intact; `clear` drops `overflow` to 0.
- FIFO full with `out_ack`=1 and a completing pixel in the same cycle -> count stays 4, `overflow` stays 0, words drain in order.
- Assert `n_rst` low after 2 pixels, release, then send 4 pixels 0x01..0x04 -> one word 0x04030201. All outputs read 0 during reset.
